button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
- Conditions raw push-button inputs before they reach the LED output stage.
- Per button: synchronizes the pin to the clock, filters contact bounce, and produces a clean level, one-cycle press/release pulses and a press-toggled state.
- Sits directly upstream of the LED driver, which consumes `pressed` or `toggle` in place of the raw pins.

Parameters:
- NB, 2, number of independent button channels (1..8).
- DEBOUNCE_CYCLES, 1000000, clock cycles the synchronized input must hold a new level before it is accepted (10 ms at 100 MHz); legal range 2..2^24.
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed (board buttons to GND with pull-ups); 0 = active-high pin.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- but  input  NB  raw asynchronous button pins.
- pressed  output  NB  debounced level, 1 = button held.
- press_pulse  output  NB  1-cycle strobe when `pressed` goes 0->1.
- release_pulse  output  NB  1-cycle strobe when `pressed` goes 1->0.
- toggle  output  NB  inverts on every press_pulse; drives LEDs as on/off latches.

Behaviour:
- Polarity: `act = but ^ {NB{ACTIVE_LOW}}`; all internal logic uses active-high "pressed" sense.
- Synchronizer: 2 flops per channel (s1, s2).
  - On reset both hold "released", so no spurious press follows reset.
  - s2 is the only signal used downstream.
- Per-channel filter, counter width = clog2(DEBOUNCE_CYCLES):
  - s2 == stable: cnt <= 0.
  - s2 != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, and the matching pulse asserts on the same edge.
  - Any bounce back to the stable level restarts the count from 0; counting never resumes from a partial value.
- Latency: count the first edge that samples the new pin level as edge 1; `pressed` updates on edge DEBOUNCE_CYCLES+2 if the pin holds steady throughout. Pulses and `toggle` update on that same edge.
- Pulses: registered, high exactly 1 cycle, never both high in one channel. A release can only follow a full debounce interval after a press.
- toggle: `toggle <= toggle ^ press_pulse_next`; release does not affect it.
- Channels are fully independent. Simultaneous presses on several channels yield simultaneous pulses with no arbitration.
- Reset, including mid-count: s1, s2, stable, cnt, pressed, press_pulse, release_pulse and toggle all clear to 0.
  - A button held through reset is reported pressed DEBOUNCE_CYCLES+2 edges after rst deasserts, with a press_pulse.
- All outputs driven directly from flops; no combinational path from `but` to any output.

Decomposition:
- Shared package / include file holds:
  - `DEB_DEFAULT_CYCLES` (1000000);
  - `DEB_SIM_CYCLES` (8);
  - the board clock frequency constant (100000000), used to derive ms-based cycle counts.
- One sub-module, `debounce_channel`: single-bit synchronizer, counter, stable flop and pulse/toggle logic, parameterized by DEBOUNCE_CYCLES.
- `button_debounce` = polarity inversion plus a generate loop of NB `debounce_channel` instances.

Test Plan (DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, NB=2):
1. Reset/idle: rst high 3 cycles, but=2'b11 -> all outputs 0 during and after reset; no pulse in the next 20 cycles.
2. Clean press: but[0] 1->0 and held.
   - pressed[0]=1, press_pulse[0]=1 and toggle[0]=1 on edge 10.
   - press_pulse[0] back to 0 on edge 11.
   - Channel 1 unchanged.
3. Bounce: but[0] low 5 cycles, high 1, low again and held -> no change before the final low run has lasted 10 edges; exactly one press_pulse.
4. Release and toggle: press, hold 20 cycles, release, repeat.
   - Two press_pulse, two release_pulse.
   - toggle[0] goes 0->1->0.
   - Pulses never overlap.
5. Simultaneous: both pins go low on the same edge -> press_pulse=2'b11 on the same cycle; toggle=2'b11.
6. Reset mid-count: but[1] low, rst asserted 1 cycle at edge 5.
   - Outputs stay 0 through the reset.
   - pressed[1]=1 exactly 10 edges after rst deasserts, with one press_pulse.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared constants for the push-button conditioning block.
// The ms helper keeps board-level debounce windows readable at instantiation sites.
package button_debounce_pkg;

    localparam int unsigned DEB_CLK_HZ         = 100_000_000;
    localparam int unsigned DEB_DEFAULT_CYCLES = 1_000_000;
    localparam int unsigned DEB_SIM_CYCLES     = 8;

    function automatic int unsigned deb_ms_to_cycles(input int unsigned ms);
        return ms * (DEB_CLK_HZ / 1000);
    endfunction

    // The counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, bounce filter, registered
// press/release strobes and a press-toggled latch. Input is active-high.
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic toggle
);

    localparam int unsigned     CW       = deb_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_pulse_q, press_pulse_d;
    logic          release_pulse_q, release_pulse_d;
    logic          toggle_q, toggle_d;

    always_comb begin
        s1_d            = act;
        s2_d            = s1_q;
        stable_d        = stable_q;
        cnt_d           = '0;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        // Any sample matching the stable level drops the count back to zero.
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d        = s2_q;
                press_pulse_d   = s2_q;
                release_pulse_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        toggle_d = toggle_q ^ press_pulse_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q            <= 1'b0;
            s2_q            <= 1'b0;
            stable_q        <= 1'b0;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            toggle_q        <= 1'b0;
        end else begin
            s1_q            <= s1_d;
            s2_q            <= s2_d;
            stable_q        <= stable_d;
            cnt_q           <= cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            toggle_q        <= toggle_d;
        end
    end

    assign pressed       = stable_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign toggle        = toggle_q;

endmodule

// File: rtl/button_debounce.sv
// NB independent debounced button channels feeding the LED driver.
// Pin polarity is normalised here so every channel works in "pressed = 1" sense.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned NB              = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_DEFAULT_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NB-1:0] but,
    output logic [NB-1:0] pressed,
    output logic [NB-1:0] press_pulse,
    output logic [NB-1:0] release_pulse,
    output logic [NB-1:0] toggle
);

    logic [NB-1:0] act;

    assign act = but ^ {NB{ACTIVE_LOW}};

    for (genvar g = 0; g < NB; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .act          (act[g]),
            .pressed      (pressed[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .toggle       (toggle[g])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random pin activity,
// checked every cycle against a sliding-window reference model.
module tb_button_debounce;
    import button_debounce_pkg::*;

    localparam int NB = 2;
    localparam int D  = DEB_SIM_CYCLES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] but = '1;
    logic [NB-1:0] pressed, press_pulse, release_pulse, toggle;

    button_debounce #(
        .NB(NB), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .but(but),
        .pressed(pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .toggle(toggle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the filter sees the pin two clocks late; a level is accepted
    // once the last D filter samples all show the opposite of the current level.
    logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_pr = '0, m_pp = '0, m_rp = '0, m_tg = '0;
    logic [D-1:0]  m_win [NB];

    initial for (int c = 0; c < NB; c++) m_win[c] = '0;

    always @(posedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (rst) begin
                m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_pr[c] = 1'b0;
                m_pp[c] = 1'b0; m_rp[c] = 1'b0; m_tg[c] = 1'b0;
                m_win[c] = '0;
            end else begin
                m_win[c] = {m_win[c][D-2:0], m_d2[c]};
                m_d2[c]  = m_d1[c];
                m_d1[c]  = ~but[c];
                m_pp[c]  = 1'b0;
                m_rp[c]  = 1'b0;
                if (m_win[c] == {D{~m_pr[c]}}) begin
                    m_pr[c] = ~m_pr[c];
                    m_pp[c] = m_pr[c];
                    m_rp[c] = ~m_pr[c];
                    m_tg[c] = m_tg[c] ^ m_pr[c];
                end
            end
        end
    end

    bit chk_en = 1'b0;
    int pp_cnt [NB];
    int rp_cnt [NB];

    initial for (int c = 0; c < NB; c++) begin pp_cnt[c] = 0; rp_cnt[c] = 0; end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pressed",       32'(pressed),       32'(m_pr));
            chk("press_pulse",   32'(press_pulse),   32'(m_pp));
            chk("release_pulse", 32'(release_pulse), 32'(m_rp));
            chk("toggle",        32'(toggle),        32'(m_tg));
            chk("pulse_overlap", 32'(press_pulse & release_pulse), 32'd0);
            for (int c = 0; c < NB; c++) begin
                pp_cnt[c] += int'(press_pulse[c]);
                rp_cnt[c] += int'(release_pulse[c]);
            end
        end
    end

    // Edges until pressed[c]==v, counted from the edge after the call; -1 on timeout.
    task automatic wait_pr(input int c, input logic v, output int n);
        n = -1;
        for (int e = 1; e <= 4 * D + 10; e++) begin
            @(negedge clk);
            if (pressed[c] === v) begin
                n = e;
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int n, p0, r0;
    logic t0;
    logic [NB-1:0] tg_before;
    int hold [NB];

    initial begin
        // 1: reset and idle with pins released
        @(posedge clk);
        chk_en = 1'b1;
        idle(3);
        chk("rst_outputs", 32'({pressed, press_pulse, release_pulse, toggle}), 32'd0);
        rst = 1'b0;
        idle(20);
        chk("idle_no_pulse", 32'(pp_cnt[0] + pp_cnt[1] + rp_cnt[0] + rp_cnt[1]), 32'd0);

        // 2: clean press on channel 0
        but = 2'b10;
        wait_pr(0, 1'b1, n);
        chk("lat_press", 32'(n), 32'(D + 2));
        chk("pp_at_press", 32'(press_pulse), 32'b01);
        chk("tog_at_press", 32'(toggle[0]), 32'd1);
        chk("ch1_idle", 32'(pressed[1]), 32'd0);
        @(negedge clk);
        chk("pp_clears", 32'(press_pulse[0]), 32'd0);
        idle(10);
        but = 2'b11;
        wait_pr(0, 1'b0, n);
        chk("lat_release", 32'(n), 32'(D + 2));
        idle(5);

        // 3: bounce - low 5, high 1, then low held
        p0 = pp_cnt[0];
        but = 2'b10; idle(5);
        but = 2'b11; idle(1);
        but = 2'b10;
        wait_pr(0, 1'b1, n);
        chk("lat_bounce", 32'(n), 32'(D + 2));
        idle(5);
        chk("bounce_one_pulse", 32'(pp_cnt[0] - p0), 32'd1);
        but = 2'b11;
        wait_pr(0, 1'b0, n);
        idle(5);

        // 4: two press/release cycles, toggle returns to start
        p0 = pp_cnt[0]; r0 = rp_cnt[0]; t0 = toggle[0];
        for (int k = 1; k <= 2; k++) begin
            but = 2'b10;
            wait_pr(0, 1'b1, n);
            chk("rep_press_lat", 32'(n), 32'(D + 2));
            chk("rep_tog_press", 32'(toggle[0]), 32'(t0 ^ k[0]));
            idle(20);
            but = 2'b11;
            wait_pr(0, 1'b0, n);
            chk("rep_tog_release", 32'(toggle[0]), 32'(t0 ^ k[0]));
            idle(5);
        end
        chk("rep_pp_count", 32'(pp_cnt[0] - p0), 32'd2);
        chk("rep_rp_count", 32'(rp_cnt[0] - r0), 32'd2);
        chk("rep_tog_final", 32'(toggle[0]), 32'(t0));

        // 5: simultaneous press on both channels
        tg_before = toggle;
        but = 2'b00;
        wait_pr(0, 1'b1, n);
        chk("sim_lat", 32'(n), 32'(D + 2));
        chk("sim_pp", 32'(press_pulse), 32'b11);
        chk("sim_pressed", 32'(pressed), 32'b11);
        chk("sim_toggle", 32'(toggle), 32'(tg_before ^ 2'b11));
        idle(5);
        but = 2'b11;
        wait_pr(0, 1'b0, n);
        idle(12);

        // 6: reset in the middle of a channel-1 count
        but = 2'b01;
        idle(4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", 32'({pressed, press_pulse, release_pulse, toggle}), 32'd0);
        rst = 1'b0;
        p0 = pp_cnt[1];
        wait_pr(1, 1'b1, n);
        chk("midrst_lat", 32'(n), 32'(D + 2));
        idle(3);
        chk("midrst_one_pulse", 32'(pp_cnt[1] - p0), 32'd1);

        // Random pin activity with occasional resets
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    but[c]  = ~but[c];
                    hold[c] = int'($urandom_range(1, 2 * D + 4));
                end else begin
                    hold[c]--;
                end
            end
            rst = ($urandom_range(0, 199) == 0);
        end
        rst = 1'b0;
        idle(2 * D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
